// File: rtl/sram_arbiter.sv
// sram_arbiter
// Two-requester arbiter in front of a single-port-per-direction SRAM, with a
// built-in clear sweep that zeroes the whole memory.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   req/we/addr/wdata   : per-requester request, op (1 = write), address, data;
//                         requester i owns bit i / slice [i*AW +: AW] / [i*WIDTH +: WIDTH]
//   gnt                 : combinational one-hot-or-zero grant, same cycle as the request
//   rvalid/rdata        : read return strobe (bit i = requester i) and shared data
//   clr_start           : start a clear sweep (ignored while one is running)
//   clr_busy/clr_done   : sweep running / one-cycle completion pulse
//   mem_*               : registered SRAM write/read port, mem_rd_data returns
//                         RD_LAT cycles after the cycle mem_rden is high
module sram_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [2*AW-1:0]    addr,
    input  logic [2*WIDTH-1:0] wdata,
    output logic [1:0]         gnt,
    output logic [1:0]         rvalid,
    output logic [WIDTH-1:0]   rdata,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               mem_wren,
    output logic               mem_rden,
    output logic [AW-1:0]      mem_wr_addr,
    output logic [AW-1:0]      mem_rd_addr,
    output logic [WIDTH-1:0]   mem_wr_data,
    input  logic [WIDTH-1:0]   mem_rd_data
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic              last_reg;          // index of the requester granted last
    logic [AW-1:0]     clr_cnt_reg;
    logic              clr_done_reg;
    logic              mem_wren_reg, mem_rden_reg;
    logic [AW-1:0]     mem_wr_addr_reg, mem_rd_addr_reg;
    logic [WIDTH-1:0]  mem_wr_data_reg;

    // Read tag pipeline: stage 0 is loaded at the grant edge, stage RD_LAT
    // lines up with the cycle mem_rd_data is valid for that read.
    logic [RD_LAT:0]   tag_valid_reg;
    logic [RD_LAT:0]   tag_id_reg;

    logic              gnt_any;
    logic              gnt_idx;
    logic              clr_last;

    logic [AW-1:0]     addr_arr  [2];
    logic [WIDTH-1:0]  wdata_arr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign clr_last = (clr_cnt_reg == AW'(DEPTH - 1));

    always_comb begin
        state_next = state_reg;
        gnt        = 2'b00;
        gnt_any    = 1'b0;
        gnt_idx    = 1'b0;
        case (state_reg)
            ARB: begin
                if (clr_start) begin
                    // Clear wins over any pending request; requests stay pending.
                    state_next = CLEAR;
                end else if (!rst && (req != 2'b00)) begin
                    gnt_any = 1'b1;
                    // On a tie the requester that was not granted last wins.
                    gnt_idx = (req == 2'b11) ? ~last_reg : req[1];
                    gnt     = gnt_idx ? 2'b10 : 2'b01;
                end
            end
            CLEAR: begin
                if (clr_last) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ARB;
            last_reg        <= 1'b1;
            clr_cnt_reg     <= '0;
            clr_done_reg    <= 1'b0;
            mem_wren_reg    <= 1'b0;
            mem_rden_reg    <= 1'b0;
            mem_wr_addr_reg <= '0;
            mem_rd_addr_reg <= '0;
            mem_wr_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_done_reg <= (state_reg == CLEAR) && clr_last;
            if (state_reg == CLEAR) begin
                // Counter wraps back to 0 on the last address, ready for next sweep.
                clr_cnt_reg     <= clr_cnt_reg + 1'b1;
                mem_wren_reg    <= 1'b1;
                mem_rden_reg    <= 1'b0;
                mem_wr_addr_reg <= clr_cnt_reg;
                mem_wr_data_reg <= '0;
            end else begin
                clr_cnt_reg  <= '0;
                mem_wren_reg <= gnt_any && we[gnt_idx];
                mem_rden_reg <= gnt_any && !we[gnt_idx];
                if (gnt_any) begin
                    last_reg <= gnt_idx;
                    if (we[gnt_idx]) begin
                        mem_wr_addr_reg <= addr_arr[gnt_idx];
                        mem_wr_data_reg <= wdata_arr[gnt_idx];
                    end else begin
                        mem_rd_addr_reg <= addr_arr[gnt_idx];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= 1'b0;
        end else begin
            tag_valid_reg[0] <= gnt_any && !we[gnt_idx];
            tag_id_reg[0]    <= gnt_idx;
        end
    end

    generate
        for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= 1'b0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rvalid      = tag_valid_reg[RD_LAT] ? (tag_id_reg[RD_LAT] ? 2'b10 : 2'b01) : 2'b00;
    assign rdata       = (rvalid != 2'b00) ? mem_rd_data : '0;
    assign clr_busy    = (state_reg == CLEAR);
    assign clr_done    = clr_done_reg;
    assign mem_wren    = mem_wren_reg;
    assign mem_rden    = mem_rden_reg;
    assign mem_wr_addr = mem_wr_addr_reg;
    assign mem_rd_addr = mem_rd_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed stimulus, a behavioural model checked on
// every cycle, and literal expectations for the scenarios of interest.
module tb_sram_arbiter;

    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int L  = 1;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clr_start = 1'b0;
    logic [1:0]      req = 2'b00;
    logic [1:0]      we = 2'b00;
    logic [2*AW-1:0] addr = '0;
    logic [2*W-1:0]  wdata = '0;
    logic [1:0]      gnt, rvalid;
    logic [W-1:0]    rdata;
    logic            clr_busy, clr_done;
    logic            mem_wren, mem_rden;
    logic [AW-1:0]   mem_wr_addr, mem_rd_addr;
    logic [W-1:0]    mem_wr_data, mem_rd_data;

    int n_vec = 0;
    int n_bad = 0;

    sram_arbiter #(.WIDTH(W), .DEPTH(D), .RD_LAT(L)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // SRAM with one cycle read latency
    logic [W-1:0] sram [D];
    logic [W-1:0] sram_q = '0;
    initial for (int i = 0; i < D; i++) sram[i] = '0;
    always @(posedge clk) begin
        if (mem_wren) sram[mem_wr_addr] <= mem_wr_data;
        if (mem_rden) sram_q <= sram[mem_rd_addr];
    end
    assign mem_rd_data = sram_q;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int id; logic [W-1:0] val; } ret_t;
    ret_t          ret_q[$];
    logic [W-1:0]  mdl_mem [D];
    int            cyc = 0;
    bit            m_clearing = 0, m_done = 0, m_last = 1;
    int            m_cnt = 0;
    bit            m_wren = 0, m_rden = 0;
    int            m_waddr = 0, m_raddr = 0;
    logic [W-1:0]  m_wdata = '0;
    initial for (int i = 0; i < D; i++) mdl_mem[i] = '0;

    always @(negedge clk) begin
        logic [1:0]   eg, er;
        logic [W-1:0] ed;
        int           gi, a;
        cyc++;
        eg = 2'b00;
        if (!rst && !m_clearing && !clr_start) begin
            if (req == 2'b11) eg = m_last ? 2'b01 : 2'b10;
            else              eg = req;
        end
        er = 2'b00;
        ed = '0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            er = (ret_q[0].id == 1) ? 2'b10 : 2'b01;
            ed = ret_q[0].val;
            void'(ret_q.pop_front());
        end
        chk("gnt", gnt, eg);
        chk("clr_busy", clr_busy, m_clearing);
        chk("clr_done", clr_done, m_done);
        chk("mem_wren", mem_wren, m_wren);
        chk("mem_rden", mem_rden, m_rden);
        if (m_wren) begin
            chk("mem_wr_addr", mem_wr_addr, m_waddr);
            chk("mem_wr_data", mem_wr_data, m_wdata);
        end
        if (m_rden) chk("mem_rd_addr", mem_rd_addr, m_raddr);
        chk("rvalid", rvalid, er);
        if (er != 2'b00) chk("rdata", rdata, ed);

        // advance to the state after the coming rising edge
        m_wren = 0;
        m_rden = 0;
        m_done = 0;
        if (rst) begin
            m_clearing = 0;
            m_last = 1;
            m_cnt = 0;
            ret_q.delete();
        end else if (m_clearing) begin
            m_wren = 1; m_waddr = m_cnt; m_wdata = '0;
            mdl_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == D) begin m_clearing = 0; m_done = 1; end
        end else if (clr_start) begin
            m_clearing = 1;
            m_cnt = 0;
        end else if (eg != 2'b00) begin
            gi = (eg == 2'b10) ? 1 : 0;
            a  = int'(addr[gi*AW +: AW]);
            m_last = gi[0];
            if (we[gi]) begin
                m_wren = 1; m_waddr = a; m_wdata = wdata[gi*W +: W];
                mdl_mem[a] = wdata[gi*W +: W];
            end else begin
                m_rden = 1; m_raddr = a;
                ret_q.push_back('{due: cyc + 1 + L, id: gi, val: mdl_mem[a]});
            end
        end
    end

    // ---------------- observation ----------------
    logic [W-1:0] rq0[$], rq1[$];
    int busy_cnt = 0, done_cnt = 0, rv1_busy = 0;
    always @(negedge clk) begin
        if (rvalid[0]) rq0.push_back(rdata);
        if (rvalid[1]) rq1.push_back(rdata);
        if (clr_busy) busy_cnt++;
        if (clr_done) done_cnt++;
        if (rvalid[1] && clr_busy) rv1_busy++;
    end

    task automatic op(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        int n;
        req[i] = 1'b1; we[i] = w; addr[i*AW +: AW] = a; wdata[i*W +: W] = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[i] && n < 3000);
        if (!gnt[i]) begin
            n_vec++; n_bad++;
            $display("FAIL gnt_timeout: requester %0d got no gnt in %0d cycles, gnt required", i, n);
        end
        $display("op req%0d we=%0d addr=%03h data=%08h granted after %0d cycle(s)", i, w, a, d, n);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!clr_done && n < lim);
        chk("clr_done_seen", clr_done, 1'b1);
    endtask

    initial begin
        logic [1:0] seq [6];
        int n;

        // reset
        idle(3);
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_wren", mem_wren, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // tie arbitration: 6 cycles of req=11 reads
        addr = {10'h011, 10'h010}; we = 2'b00; req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seq[k] = gnt;
            $display("tie cycle %0d gnt=%b", k, gnt);
        end
        @(posedge clk); #1;
        req = 2'b00;
        for (int k = 0; k < 6; k++) chk("tie_seq", seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        idle(5);
        chk("tie_rv0_count", rq0.size(), 3);
        chk("tie_rv1_count", rq1.size(), 3);

        // write 1..16 to 0..15 then read back
        for (int k = 0; k < 16; k++) op(0, 1'b1, AW'(k), W'(k + 1));
        rq0.delete();
        for (int k = 0; k < 16; k++) op(0, 1'b0, AW'(k), '0);
        idle(5);
        chk("readback_count", rq0.size(), 16);
        for (int k = 0; k < 16 && k < rq0.size(); k++) chk("readback_data", rq0[k], W'(k + 1));

        // clear sweep
        op(0, 1'b1, 10'h3FF, 32'hAA);
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        wait_done(1100);
        idle(3);
        chk("clr_busy_cycles", busy_cnt, D);
        chk("clr_done_pulses", done_cnt, 1);
        op(0, 1'b0, 10'h3FF, '0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid[0] && n < 20);
        chk("rd_latency", n, 1 + L);
        chk("rd_3ff_after_clear", rdata, 32'h0);
        $display("read 3FF after clear: rdata=%08h after %0d cycle(s)", rdata, n);

        // read in flight across clr_start, request held through CLEAR
        op(1, 1'b1, 10'h005, 32'h55);
        rq1.delete(); rv1_busy = 0; busy_cnt = 0;
        op(1, 1'b0, 10'h005, '0);
        clr_start = 1'b1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AW] = 10'h007;
        @(posedge clk); #1;
        clr_start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[0] && n < 1200);
        chk("held_gnt_at_done", {gnt, clr_done}, 3'b011);
        chk("held_busy_before_gnt", busy_cnt, D);
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("rv_during_clear", rv1_busy, 1);
        chk("rv_during_clear_data", (rq1.size() > 0) ? rq1[0] : 32'hDEAD, 32'h55);
        idle(3);

        // reset drops an in-flight read
        n = rq0.size();
        op(0, 1'b0, 10'h002, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        chk("rst_drops_read", rq0.size(), n);

        // reset mid-clear
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_wren && mem_wr_addr == 10'h100) && n < 2000);
        chk("clr_reached_100", mem_wr_addr, 10'h100);
        rst = 1'b1;
        done_cnt = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_outputs", {gnt, rvalid, rdata, clr_busy, clr_done, mem_wren, mem_rden},
            '0);
        chk("rst_mid_mem_bus", {mem_wr_addr, mem_rd_addr, mem_wr_data}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(20);
        chk("rst_mid_no_done", done_cnt, 0);
        addr = {10'h021, 10'h020}; we = 2'b00; req = 2'b11;
        @(negedge clk);
        chk("tie_after_rst", gnt, 2'b01);
        @(posedge clk); #1;
        req = 2'b00;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 WIDTH, default 32, SHALL set the data word width.
REQ-002 DEPTH, default 1024, SHALL set the word count; must be a power of two; AW = $clog2(DEPTH).
REQ-003 RD_LAT, default 1, SHALL equal the SRAM read latency in cycles from the rden sample edge to valid rd_data.
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req  in  2  per-requester request; bit i belongs to requester i.
REQ-008 we  in  2  per-requester op: 1 = write, 0 = read.
REQ-009 addr  in  2*AW  requester i address in bits [i*AW +: AW].
REQ-010 wdata  in  2*WIDTH  requester i write data in bits [i*WIDTH +: WIDTH].
REQ-011 gnt  out  2  one-hot-or-zero grant, combinational, same cycle as the accepted req.
REQ-012 rvalid  out  2  read-return strobe; bit i marks data for requester i.
REQ-013 rdata  out  WIDTH  read data, shared; meaningful only while rvalid != 0.
REQ-014 clr_start  in  1  request to zero the whole memory.
REQ-015 clr_busy  out  1  high while the clear sweep runs.
REQ-016 clr_done  out  1  one-cycle pulse when the sweep completes.
REQ-017 mem_wren / mem_rden  out  1 each  registered SRAM write and read enables.
REQ-018 mem_wr_addr / mem_rd_addr  out  AW each  registered SRAM addresses.
REQ-019 mem_wr_data  out  WIDTH  registered SRAM write data.
REQ-020 mem_rd_data  in  WIDTH  SRAM read data.

Function
REQ-021 The FSM SHALL have two states: ARB (after reset) and CLEAR.
REQ-022 ARB: at most one gnt bit SHALL be high per cycle, only for a requester with req high.
REQ-023 Single requester: that requester SHALL be granted immediately.
REQ-024 Both requesting: the requester not granted last SHALL win; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-025 The pointer SHALL update only on a grant.
REQ-026 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the transaction completes in the gnt cycle.
REQ-027 Grant in cycle T SHALL drive exactly one mem_wren or mem_rden pulse in cycle T+1 with the granted address/data; all other cycles drive enables 0.
REQ-028 A read granted in cycle T SHALL return rvalid[i]=1 with rdata = mem_rd_data in cycle T+1+RD_LAT, for one cycle; writes produce no rvalid.
REQ-029 Back-to-back reads SHALL be fully pipelined (one per cycle); return order equals grant order; a RD_LAT+1 deep tag shift register tracks the requester id.
REQ-030 clr_start high in ARB SHALL suppress all grants that cycle and enter CLEAR next cycle; clr_start SHALL be ignored in CLEAR.
REQ-031 CLEAR SHALL issue mem_wren with mem_wr_data = 0 for addresses 0 to DEPTH-1, one per cycle, in ascending order, with no gnt.
REQ-032 clr_busy SHALL be high exactly during the DEPTH cycles of CLEAR.
REQ-033 clr_done SHALL pulse the cycle after the last clear write, in the same cycle the FSM re-enters ARB; arbitration resumes that cycle.
REQ-034 Reads granted before CLEAR SHALL still return their rvalid during CLEAR.
REQ-035 Simultaneous clr_start and req SHALL give clear priority; the requests stay pending.

Reset
REQ-036 rst SHALL force state ARB, pointer 1, clear counter 0, and tag pipeline empty; all outputs go to 0 (gnt, rvalid, rdata, clr_busy, clr_done, mem_*) from the next edge.
REQ-037 rst mid-operation SHALL abort CLEAR without clr_done and drop in-flight reads (no rvalid).

Verification
REQ-038 Requester 0 writes 32'h1..32'h10 to addresses 0x0..0xF, then reads them back: rvalid[0] returns 32'h1..32'h10 in order, 2+RD_LAT-1 cycles after each gnt.
REQ-039 req=2'b11 held for 6 cycles, all reads: gnt alternates 01,10,01,10,01,10; rvalid tags match.
REQ-040 Write 32'hAA to address 0x3FF, pulse clr_start: clr_busy high 1024 cycles, clr_done pulses once, read of 0x3FF returns 0.
REQ-041 Read granted in the cycle before clr_start: its rvalid still arrives during CLEAR; req held during CLEAR gets no gnt until clr_done.
REQ-042 rst asserted at clear address 0x100: no clr_done, all outputs 0; the next tie grants requester 0.
